// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// cdb_arbiter_pkg: CDB / RVFI payload types, source indices and round-robin helper.
// Rev 1.0
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC = 4;
  localparam int CDB_TAG_W   = 4;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MUL  = 2'd1,
    SRC_CMP  = 2'd2,
    SRC_LOAD = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [31:0]          value;
    logic                 br_en;
    logic [31:0]          br_target;
  } cdb_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_data;

  // One buffered result: the bus payload and the RVFI record that travels with it.
  typedef struct packed {
    cdb_t     cdb;
    rvfi_data rvfi;
  } cdb_entry_t;

  function automatic int rr_next(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// cdb_src_fifo: per-source result FIFO with ready backpressure and flush.
// Rev 1.0
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  cdb_entry_t             wr_data,
  output cdb_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  // Ready depends only on the current fill level: a same-cycle pop does not free a slot.
  assign ready   = ~rst & (count < FULL_COUNT);
  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// cdb_arbiter: buffers per-unit results and serialises them round-robin onto the registered CDB.
// Rev 1.0
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  cdb_t               src_in   [NUM_SRC],
  input  rvfi_data           src_rvfi [NUM_SRC],
  output logic [NUM_SRC-1:0] src_ready,
  output cdb_t               cdb_out,
  output rvfi_data           rvfi_out
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  cdb_entry_t         head  [NUM_SRC];
  logic [CNT_W-1:0]   count [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   rr_ptr_next;
  logic [SEL_W-1:0]   grant_idx;
  logic               grant_valid;
  cdb_entry_t         grant_entry;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign push[i]  = src_in[i].valid & src_ready[i];
      assign pop[i]   = grant_valid & (grant_idx == SEL_W'(i));
      assign empty[i] = (count[i] == '0);

      cdb_src_fifo #(
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push[i]),
        .pop     (pop[i]),
        .wr_data ({src_in[i], src_rvfi[i]}),
        .head    (head[i]),
        .count   (count[i]),
        .ready   (src_ready[i])
      );
    end
  endgenerate

  // Scan starts at rr_ptr so the source after the last winner has top priority.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SEL_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign rr_ptr_next = SEL_W'(rr_next(int'(grant_idx), NUM_SRC));
  assign grant_entry = head[grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_out  <= '0;
      rvfi_out <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      cdb_out  <= '0;
      rvfi_out <= '0;
    end else if (grant_valid) begin
      cdb_out       <= grant_entry.cdb;
      cdb_out.valid <= 1'b1;
      rvfi_out      <= grant_entry.rvfi;
      rr_ptr        <= rr_ptr_next;
    end else begin
      cdb_out  <= '0;
      rvfi_out <= '0;
    end
  end

endmodule
`default_nettype wire
